// File: rtl/param_pipe_core.sv
// Parametrised 4-stage (IF/ID/EX/WB) pipelined core with load-use/branch hazard control.
// Optional feature macro: PIPE_FWD_EN enables EX->ID forwarding of ALU/LDI results.
module param_pipe_core #(
  parameter int DATA_W = 19,
  parameter int REG_AW = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted
);

  localparam int NREG   = 1 << REG_AW;
  localparam int DMEM_D = 1 << ADDR_W;
  localparam int RD_HI  = ADDR_W + 3*REG_AW - 1;
  localparam int RS1_HI = ADDR_W + 2*REG_AW - 1;
  localparam int RS2_HI = ADDR_W + REG_AW - 1;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_LDI  = 5'd6;
  localparam logic [4:0] OP_LD   = 5'd7;
  localparam logic [4:0] OP_ST   = 5'd8;
  localparam logic [4:0] OP_JMP  = 5'd9;
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_HALT = 5'd11;

  function automatic logic writes_reg(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_LD};
  endfunction

  // Pipeline state
  logic [ADDR_W-1:0] r_pc;
  logic              r_fetch_stop;
  logic              r_ifid_valid;
  logic [DATA_W-1:0] r_ifid_instr;
  logic [4:0]        r_idex_op;
  logic [REG_AW-1:0] r_idex_rd;
  logic [DATA_W-1:0] r_idex_a;
  logic [DATA_W-1:0] r_idex_b;
  logic [ADDR_W-1:0] r_idex_imm;
  logic              r_exwb_wr;
  logic [REG_AW-1:0] r_exwb_rd;
  logic [DATA_W-1:0] r_exwb_data;
  logic              r_halted;
  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_dmem [DMEM_D];

  // Decode
  logic [4:0]        w_id_op;
  logic [REG_AW-1:0] w_id_rd, w_id_rs1, w_id_rs2;
  logic [ADDR_W-1:0] w_id_imm;
  logic              w_id_use1, w_id_use2, w_id_halt;
  logic              w_ex_wr, w_dep1, w_dep2, w_stall;
  logic              w_taken, w_redirect;
  logic [DATA_W-1:0] w_rs1_val, w_rs2_val, w_ex_result;

  assign w_id_op   = r_ifid_valid ? r_ifid_instr[DATA_W-1 -: 5] : OP_NOP;
  assign w_id_rd   = r_ifid_instr[RD_HI  -: REG_AW];
  assign w_id_rs1  = r_ifid_instr[RS1_HI -: REG_AW];
  assign w_id_rs2  = r_ifid_instr[RS2_HI -: REG_AW];
  assign w_id_imm  = r_ifid_instr[ADDR_W-1:0];
  assign w_id_use1 = w_id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ST, OP_BEQ};
  assign w_id_use2 = w_id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BEQ};
  assign w_id_halt = (w_id_op == OP_HALT);

  assign w_ex_wr = writes_reg(r_idex_op);
  assign w_dep1  = w_id_use1 && w_ex_wr && (r_idex_rd == w_id_rs1);
  assign w_dep2  = w_id_use2 && w_ex_wr && (r_idex_rd == w_id_rs2);

`ifdef PIPE_FWD_EN
  logic w_ex_fwd_ok;
  assign w_ex_fwd_ok = (r_idex_op != OP_LD);
  // Branch compare is never forwarded, and a load result is not ready until WB.
  assign w_stall = (w_dep1 || w_dep2) && (!w_ex_fwd_ok || (w_id_op == OP_BEQ));
`else
  assign w_stall = w_dep1 || w_dep2;
`endif

  always_comb begin
    w_rs1_val = r_regs[w_id_rs1];
    w_rs2_val = r_regs[w_id_rs2];
    // Write-first register file: the retiring WB value wins over the stored one.
    if (r_exwb_wr && (r_exwb_rd == w_id_rs1)) w_rs1_val = r_exwb_data;
    if (r_exwb_wr && (r_exwb_rd == w_id_rs2)) w_rs2_val = r_exwb_data;
`ifdef PIPE_FWD_EN
    if (w_dep1 && w_ex_fwd_ok) w_rs1_val = w_ex_result;
    if (w_dep2 && w_ex_fwd_ok) w_rs2_val = w_ex_result;
`endif
  end

  assign w_taken    = (w_id_op == OP_JMP) || ((w_id_op == OP_BEQ) && (w_rs1_val == w_rs2_val));
  assign w_redirect = w_taken && !w_stall;

  always_comb begin
    w_ex_result = '0;
    case (r_idex_op)
      OP_ADD:  w_ex_result = r_idex_a + r_idex_b;
      OP_SUB:  w_ex_result = r_idex_a - r_idex_b;
      OP_AND:  w_ex_result = r_idex_a & r_idex_b;
      OP_OR:   w_ex_result = r_idex_a | r_idex_b;
      OP_XOR:  w_ex_result = r_idex_a ^ r_idex_b;
      OP_LDI:  w_ex_result = {{(DATA_W-ADDR_W){1'b0}}, r_idex_imm};
      OP_LD:   w_ex_result = r_dmem[r_idex_imm];
      default: w_ex_result = '0;
    endcase
  end

  // Fetch handshake: imem_data is consumed at a rising edge only when imem_valid=1 and IF
  // is free to advance (no stall, no halt, no redirect); otherwise the PC simply holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc         <= '0;
      r_fetch_stop <= 1'b0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_idex_op    <= OP_NOP;
      r_idex_rd    <= '0;
      r_idex_a     <= '0;
      r_idex_b     <= '0;
      r_idex_imm   <= '0;
      r_exwb_wr    <= 1'b0;
      r_exwb_rd    <= '0;
      r_exwb_data  <= '0;
      r_halted     <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_stall) begin
        r_ifid_valid <= r_ifid_valid;
      end else if (r_fetch_stop || w_id_halt) begin
        r_ifid_valid <= 1'b0;
      end else if (w_redirect) begin
        r_pc         <= w_id_imm;
        r_ifid_valid <= 1'b0;
      end else if (imem_valid) begin
        r_pc         <= r_pc + ADDR_W'(1);
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= imem_data;
      end else begin
        r_ifid_valid <= 1'b0;
      end
      if (w_id_halt) r_fetch_stop <= 1'b1;

      if (w_stall) begin
        r_idex_op <= OP_NOP;
      end else begin
        r_idex_op  <= w_id_op;
        r_idex_rd  <= w_id_rd;
        r_idex_a   <= w_rs1_val;
        r_idex_b   <= w_rs2_val;
        r_idex_imm <= w_id_imm;
      end

      r_exwb_wr   <= w_ex_wr;
      r_exwb_rd   <= r_idex_rd;
      r_exwb_data <= w_ex_result;
      if (r_idex_op == OP_HALT) r_halted <= 1'b1;

      if (r_exwb_wr) r_regs[r_exwb_rd] <= r_exwb_data;
    end
  end

  // Data memory has no reset; a store in EX during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && (r_idex_op == OP_ST)) r_dmem[r_idex_imm] <= r_idex_a;
  end

  assign imem_addr = r_pc;
  assign wb_valid  = r_exwb_wr;
  assign wb_addr   = r_exwb_rd;
  assign wb_data   = r_exwb_data;
  assign halted    = r_halted;

endmodule
